// File: rtl/next_pc_predictor_param.sv
// next_pc_predictor_param: fetch-stage next-PC predictor (fully-associative BTB, 2-bit BHT, return-address stack)
// Build option: define GSHARE_EN to XOR a global history register into the BHT index.
// Ports: clk_i/rst_i (async active-high); invalidate_i flushes BTB valids and resyncs the speculative RAS pointer;
//   branch_request_i + one-hot branch_is_{taken,not_taken,call,ret,jmp}_i with branch_source_i/branch_pc_i train;
//   pc_f_i/pc_accept_i drive the zero-latency lookup; next_pc_f_o/next_taken_f_o carry the prediction.
module next_pc_predictor_param #(
  parameter int BTB_ENTRIES = 32,
  parameter int BHT_ENTRIES = 256,
  parameter int RAS_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        invalidate_i,
  input  logic        branch_request_i,
  input  logic        branch_is_taken_i,
  input  logic        branch_is_not_taken_i,
  input  logic        branch_is_call_i,
  input  logic        branch_is_ret_i,
  input  logic        branch_is_jmp_i,
  input  logic [31:0] branch_source_i,
  input  logic [31:0] branch_pc_i,
  input  logic [31:0] pc_f_i,
  input  logic        pc_accept_i,
  output logic [31:0] next_pc_f_o,
  output logic        next_taken_f_o
);
  localparam int BTB_W = $clog2(BTB_ENTRIES);
  localparam int BHT_W = $clog2(BHT_ENTRIES);
  localparam int RAS_W = $clog2(RAS_DEPTH);
  typedef enum logic [1:0] {T_COND, T_CALL, T_RET, T_JMP} br_t;
  logic [BTB_ENTRIES-1:0] btb_val_q, btb_val_d;
  logic [31:0]            btb_src_q [BTB_ENTRIES];
  logic [31:0]            btb_src_d [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [31:0]            btb_tgt_d [BTB_ENTRIES];
  br_t                    btb_typ_q [BTB_ENTRIES];
  br_t                    btb_typ_d [BTB_ENTRIES];
  logic [1:0]             bht_q [BHT_ENTRIES];
  logic [1:0]             bht_d [BHT_ENTRIES];
  logic [31:0]            ras_q [RAS_DEPTH];
  logic [31:0]            ras_d [RAS_DEPTH];
  logic [RAS_W-1:0]       spec_q, spec_d, commit_q, commit_d, commit_inc;
  logic [BTB_W-1:0]       repl_q, repl_d, f_idx, r_idx, r_slot;
  logic [BHT_W-1:0]       f_bidx, r_bidx;
  logic                   f_hit, r_hit, f_taken, r_tk, r_nt, r_call, r_ret, r_jmp, r_any;
  br_t                    f_typ, r_typ;
`ifdef GSHARE_EN
  logic [BHT_W-1:0]       ghr_q, ghr_d;
  assign f_bidx = pc_f_i[BHT_W+1:2] ^ ghr_q;
  assign r_bidx = branch_source_i[BHT_W+1:2] ^ ghr_q;
  assign ghr_d  = (r_tk || r_nt) ? BHT_W'({ghr_q, r_tk}) : ghr_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ghr_q <= '0;
    else ghr_q <= ghr_d;
`else
  assign f_bidx = pc_f_i[BHT_W+1:2];
  assign r_bidx = branch_source_i[BHT_W+1:2];
`endif
  assign r_tk   = branch_request_i & branch_is_taken_i;
  assign r_nt   = branch_request_i & branch_is_not_taken_i;
  assign r_call = branch_request_i & branch_is_call_i;
  assign r_ret  = branch_request_i & branch_is_ret_i;
  assign r_jmp  = branch_request_i & branch_is_jmp_i;
  assign r_any  = r_tk | r_call | r_ret | r_jmp;
  assign r_typ  = r_call ? T_CALL : r_ret ? T_RET : r_jmp ? T_JMP : T_COND;
  // Descending scans so the lowest matching index wins.
  always_comb begin
    f_hit = 1'b0;
    f_idx = '0;
    r_hit = 1'b0;
    r_idx = '0;
    for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
      if (btb_val_q[i] && btb_src_q[i] == pc_f_i) begin
        f_hit = 1'b1;
        f_idx = BTB_W'(i);
      end
      if (branch_request_i && btb_val_q[i] && btb_src_q[i] == branch_source_i) begin
        r_hit = 1'b1;
        r_idx = BTB_W'(i);
      end
    end
  end
  assign f_typ          = btb_typ_q[f_idx];
  assign f_taken        = f_hit & (f_typ != T_COND | bht_q[f_bidx][1]);
  assign next_taken_f_o = f_taken;
  assign next_pc_f_o    = !f_taken ? pc_f_i + 32'd4 : f_typ == T_RET ? ras_q[spec_q] : btb_tgt_q[f_idx];
  assign commit_inc     = commit_q + 1'b1;
  assign commit_d       = r_call ? commit_inc : r_ret ? commit_q - 1'b1 : commit_q;
  // The committed pointer already includes this cycle's resolution when a flush resyncs.
  assign spec_d = invalidate_i ? commit_d
                : (pc_accept_i && f_taken && f_typ == T_CALL) ? spec_q + 1'b1
                : (pc_accept_i && f_taken && f_typ == T_RET) ? spec_q - 1'b1 : spec_q;
  assign r_slot = r_hit ? r_idx : repl_q;
  always_comb begin
    btb_val_d = btb_val_q;
    btb_src_d = btb_src_q;
    btb_tgt_d = btb_tgt_q;
    btb_typ_d = btb_typ_q;
    repl_d    = repl_q;
    bht_d     = bht_q;
    ras_d     = ras_q;
    if (r_hit || r_any) begin
      btb_val_d[r_slot] = 1'b1;
      btb_src_d[r_slot] = branch_source_i;
      btb_tgt_d[r_slot] = branch_pc_i;
      btb_typ_d[r_slot] = r_typ;
    end
    if (!r_hit && r_any) repl_d = repl_q + 1'b1;
    if (invalidate_i) begin
      btb_val_d = '0;
      repl_d    = repl_q;
    end
    if (r_tk && bht_q[r_bidx] != 2'b11) bht_d[r_bidx] = bht_q[r_bidx] + 2'b01;
    if (r_nt && bht_q[r_bidx] != 2'b00) bht_d[r_bidx] = bht_q[r_bidx] - 2'b01;
    if (r_call) ras_d[commit_inc] = branch_source_i + 32'd4;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btb_val_q <= '0;
      repl_q    <= '0;
      spec_q    <= '0;
      commit_q  <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_src_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_typ_q[i] <= T_COND;
      end
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      btb_val_q <= btb_val_d;
      btb_src_q <= btb_src_d;
      btb_tgt_q <= btb_tgt_d;
      btb_typ_q <= btb_typ_d;
      repl_q    <= repl_d;
      spec_q    <= spec_d;
      commit_q  <= commit_d;
      bht_q     <= bht_d;
      ras_q     <= ras_d;
    end
  end
endmodule

// File: tb/tb_next_pc_predictor_param.sv
// tb_next_pc_predictor_param: scoreboard bench for the next-PC predictor
module tb_next_pc_predictor_param;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        invalidate_i = 1'b0, branch_request_i = 1'b0;
  logic        branch_is_taken_i = 1'b0, branch_is_not_taken_i = 1'b0;
  logic        branch_is_call_i = 1'b0, branch_is_ret_i = 1'b0, branch_is_jmp_i = 1'b0;
  logic [31:0] branch_source_i = '0, branch_pc_i = '0, pc_f_i = '0;
  logic        pc_accept_i = 1'b0;
  logic [31:0] next_pc_f_o;
  logic        next_taken_f_o;
  localparam logic [4:0] K_TK = 5'b10000, K_NT = 5'b01000, K_CALL = 5'b00100, K_RET = 5'b00010, K_JMP = 5'b00001;
  int          checks = 0, errors = 0;
  string       tag_q[$];
  logic [32:0] exp_q[$];
  next_pc_predictor_param dut (
    .clk_i(clk_i), .rst_i(rst_i), .invalidate_i(invalidate_i),
    .branch_request_i(branch_request_i), .branch_is_taken_i(branch_is_taken_i),
    .branch_is_not_taken_i(branch_is_not_taken_i), .branch_is_call_i(branch_is_call_i),
    .branch_is_ret_i(branch_is_ret_i), .branch_is_jmp_i(branch_is_jmp_i),
    .branch_source_i(branch_source_i), .branch_pc_i(branch_pc_i),
    .pc_f_i(pc_f_i), .pc_accept_i(pc_accept_i),
    .next_pc_f_o(next_pc_f_o), .next_taken_f_o(next_taken_f_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h taken=%b, expected pc=%h taken=%b", tag, got[32:1], got[0], exp[32:1], exp[0]);
    end
  endtask
  task automatic step(input logic [31:0] pc, input logic acc, input logic inv, input logic [4:0] k,
                      input logic [31:0] src, input logic [31:0] tgt,
                      input logic chk, input logic [31:0] ep, input logic et, input string tag);
    @(posedge clk_i);
    #1;
    pc_f_i = pc;
    pc_accept_i = acc;
    invalidate_i = inv;
    branch_request_i = |k;
    {branch_is_taken_i, branch_is_not_taken_i, branch_is_call_i, branch_is_ret_i, branch_is_jmp_i} = k;
    branch_source_i = src;
    branch_pc_i = tgt;
    if (chk) begin
      tag_q.push_back(tag);
      exp_q.push_back({ep, et});
    end
    @(negedge clk_i);
    while (exp_q.size() > 0) check(tag_q.pop_front(), {next_pc_f_o, next_taken_f_o}, exp_q.pop_front());
  endtask
  task automatic train(input logic [4:0] k, input logic [31:0] src, input logic [31:0] tgt);
    step(32'h0, 1'b0, 1'b0, k, src, tgt, 1'b0, 32'h0, 1'b0, "");
  endtask
  task automatic look(input logic [31:0] pc, input logic acc, input logic [31:0] ep, input logic et, input string tag);
    step(pc, acc, 1'b0, 5'b0, 32'h0, 32'h0, 1'b1, ep, et, tag);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    look(32'h1000, 1'b0, 32'h1004, 1'b0, "reset_lookup");
    train(K_TK, 32'h1008, 32'h2000);
    look(32'h1008, 1'b0, 32'h2000, 1'b1, "taken_once");
    train(K_TK, 32'h1008, 32'h2000);
    look(32'h1008, 1'b0, 32'h2000, 1'b1, "taken_twice");
    train(K_TK, 32'h1008, 32'h2000);
    train(K_NT, 32'h1008, 32'h2000);
    look(32'h1008, 1'b0, 32'h2000, 1'b1, "sat_max");
    step(32'h1008, 1'b0, 1'b0, K_NT, 32'h1008, 32'h2000, 1'b1, 32'h2000, 1'b1, "no_bypass");
    look(32'h1008, 1'b0, 32'h100C, 1'b0, "weak_nt");
    train(K_TK, 32'h1008, 32'h2000);
    train(K_TK, 32'h1008, 32'h2000);
    look(32'h1008, 1'b0, 32'h2000, 1'b1, "retrained");
    train(K_NT, 32'h1020, 32'h5000);
    look(32'h1020, 1'b0, 32'h1024, 1'b0, "nt_no_alloc");
    train(K_TK, 32'h1020, 32'h5000);
    look(32'h1020, 1'b0, 32'h1024, 1'b0, "hit_weak_nt");
    train(K_TK, 32'h1020, 32'h5000);
    look(32'h1020, 1'b0, 32'h5000, 1'b1, "sat_min");
    train(K_CALL, 32'h1010, 32'h3000);
    look(32'h1010, 1'b0, 32'h3000, 1'b1, "call_hit");
    step(32'h0, 1'b0, 1'b1, 5'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, "");
    look(32'h1010, 1'b0, 32'h1014, 1'b0, "inv_cleared");
    train(K_RET, 32'h3004, 32'h1014);
    look(32'h3004, 1'b1, 32'h1014, 1'b1, "ret_target");
    look(32'h3004, 1'b0, 32'h0000, 1'b1, "ras_spec_pop");
    look(32'h3004, 1'b0, 32'h0000, 1'b1, "no_accept_hold");
    train(K_CALL, 32'h1010, 32'h3000);
    look(32'h1010, 1'b1, 32'h3000, 1'b1, "call_accept");
    look(32'h3004, 1'b0, 32'h1014, 1'b1, "ras_spec_push");
    step(32'h0, 1'b0, 1'b1, K_JMP, 32'h1030, 32'h6000, 1'b0, 32'h0, 1'b0, "");
    look(32'h1030, 1'b0, 32'h1034, 1'b0, "inv_override");
    look(32'h1008, 1'b0, 32'h100C, 1'b0, "inv_1008");
    train(K_TK, 32'h1008, 32'h2000);
    train(K_NT, 32'h1008, 32'h2000);
    look(32'h1008, 1'b0, 32'h2000, 1'b1, "bht_kept");
    step(32'h0, 1'b0, 1'b1, 5'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, "");
    for (int i = 0; i <= 32; i++) train(K_JMP, 32'h4000 + 32'(8 * i), 32'h8000 + 32'(16 * i));
    look(32'h4000, 1'b0, 32'h4004, 1'b0, "evicted");
    for (int i = 1; i <= 32; i++) look(32'h4000 + 32'(8 * i), 1'b0, 32'h8000 + 32'(16 * i), 1'b1, "btb_kept");
    @(negedge clk_i);
    pc_f_i = 32'h4008;
    #1;
    check("pre_reset", {next_pc_f_o, next_taken_f_o}, {32'h8010, 1'b1});
    rst_i = 1'b1;
    #1;
    check("async_reset", {next_pc_f_o, next_taken_f_o}, {32'h400C, 1'b0});
    @(negedge clk_i);
    rst_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
